// File: rtl/readout_pkg.sv
// Shared types and helpers for the pixel readout serializer.
// The state enum, the default frame header and the frame length helper live here.
package readout_pkg;

  typedef enum logic [1:0] {IDLE, LATCH, SEND} state_t;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

  // Frame is HEADER, idx, three counter words, then the checksum byte.
  function automatic int frame_len(input int counter_bits);
    return 3 * counter_bits / 8 + 3;
  endfunction

endpackage

// File: rtl/readout_frame_builder.sv
// Holds one pixel's snapshot and walks through its frame bytes.
// Gives the byte after the current one, so the top can keep tx_data registered.
module readout_frame_builder
  import readout_pkg::*;
#(
  parameter int         COUNTER_BITS = 32,
  parameter logic [7:0] HEADER       = HEADER_DEFAULT
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_load,
  input  logic                    i_advance,
  input  logic [7:0]              i_idx,
  input  logic [COUNTER_BITS-1:0] i_time_high,
  input  logic [COUNTER_BITS-1:0] i_time_low,
  input  logic [COUNTER_BITS-1:0] i_period,
  output logic [7:0]              o_nxt_byte,
  output logic                    o_nxt_last,
  output logic                    o_at_end
);

  localparam int FL = frame_len(COUNTER_BITS);
  localparam int PB = FL - 2;
  localparam int KW = $clog2(FL);

  logic [8*PB-1:0] r_payload;
  logic [KW-1:0]   r_k;
  logic [7:0]      r_chk;
  logic [7:0]      w_cur_byte;
  logic [7:0]      w_nxt_chk;

  // Byte k of the frame; payload is sent MSB-first, starting with the idx byte.
  function automatic logic [7:0] pick(input logic [KW-1:0] k,
                                      input logic [8*PB-1:0] pl,
                                      input logic [7:0] chk);
    logic [7:0] b;
    b = HEADER;
    if (k == KW'(FL - 1)) b = chk;
    for (int j = 0; j < PB; j++) begin
      if (k == KW'(j + 1)) b = pl[(PB-1-j)*8 +: 8];
    end
    return b;
  endfunction

  assign w_cur_byte = pick(r_k, r_payload, r_chk);
  // The header is excluded from the checksum.
  assign w_nxt_chk  = (r_k == '0) ? r_chk : (r_chk ^ w_cur_byte);
  assign o_nxt_byte = pick(r_k + 1'b1, r_payload, w_nxt_chk);
  assign o_nxt_last = (r_k == KW'(FL - 2));
  assign o_at_end   = (r_k == KW'(FL - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_payload <= '0;
      r_k       <= '0;
      r_chk     <= '0;
    end else if (i_load) begin
      r_payload <= {i_idx, i_time_high, i_time_low, i_period};
      r_k       <= '0;
      r_chk     <= '0;
    end else if (i_advance) begin
      r_k       <= r_k + 1'b1;
      r_chk     <= w_nxt_chk;
    end
  end

endmodule

// File: rtl/readout_serializer.sv
// Sweeps all pixel counter results and streams them out as framed bytes
// over a valid/ready byte interface, one snapshotted pixel per frame.
module readout_serializer
  import readout_pkg::*;
#(
  parameter int         PIXELS       = 128,
  parameter int         COUNTER_BITS = 32,
  parameter logic [7:0] HEADER       = HEADER_DEFAULT
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_start,
  input  logic [PIXELS*COUNTER_BITS-1:0] i_time_high_bus,
  input  logic [PIXELS*COUNTER_BITS-1:0] i_time_low_bus,
  input  logic [PIXELS*COUNTER_BITS-1:0] i_period_bus,
  output logic [7:0]                     o_tx_data,
  output logic                           o_tx_valid,
  input  logic                           i_tx_ready,
  output logic                           o_tx_last,
  output logic                           o_busy,
  output logic [7:0]                     o_pixel_idx
);

  localparam logic [7:0] LAST_IDX = 8'(PIXELS - 1);

  state_t                  r_state;
  logic [7:0]              r_tx_data;
  logic                    r_tx_valid;
  logic                    r_tx_last;
  logic                    r_busy;
  logic [7:0]              r_pixel_idx;

  logic [COUNTER_BITS-1:0] w_th;
  logic [COUNTER_BITS-1:0] w_tl;
  logic [COUNTER_BITS-1:0] w_per;
  logic                    w_transfer;
  logic                    w_load;
  logic                    w_advance;
  logic [7:0]              w_nxt_byte;
  logic                    w_nxt_last;
  logic                    w_at_end;

  assign w_transfer = r_tx_valid & i_tx_ready;
  assign w_load     = (r_state == LATCH);
  assign w_advance  = (r_state == SEND) & w_transfer & ~w_at_end;

  always_comb begin
    w_th  = '0;
    w_tl  = '0;
    w_per = '0;
    for (int i = 0; i < PIXELS; i++) begin
      if (r_pixel_idx == 8'(i)) begin
        w_th  = i_time_high_bus[i*COUNTER_BITS +: COUNTER_BITS];
        w_tl  = i_time_low_bus[i*COUNTER_BITS +: COUNTER_BITS];
        w_per = i_period_bus[i*COUNTER_BITS +: COUNTER_BITS];
      end
    end
  end

  readout_frame_builder #(
    .COUNTER_BITS(COUNTER_BITS),
    .HEADER      (HEADER)
  ) u_builder (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_load),
    .i_advance  (w_advance),
    .i_idx      (r_pixel_idx),
    .i_time_high(w_th),
    .i_time_low (w_tl),
    .i_period   (w_per),
    .o_nxt_byte (w_nxt_byte),
    .o_nxt_last (w_nxt_last),
    .o_at_end   (w_at_end)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_tx_data   <= '0;
      r_tx_valid  <= 1'b0;
      r_tx_last   <= 1'b0;
      r_busy      <= 1'b0;
      r_pixel_idx <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state     <= LATCH;
            r_busy      <= 1'b1;
            r_pixel_idx <= '0;
          end
        end
        LATCH: begin
          r_state    <= SEND;
          r_tx_valid <= 1'b1;
          r_tx_data  <= HEADER;
          r_tx_last  <= 1'b0;
        end
        SEND: begin
          if (w_transfer) begin
            if (w_at_end) begin
              r_tx_valid <= 1'b0;
              r_tx_last  <= 1'b0;
              if (r_pixel_idx != LAST_IDX) begin
                r_pixel_idx <= r_pixel_idx + 8'd1;
                r_state     <= LATCH;
              end else begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
              end
            end else begin
              r_tx_data <= w_nxt_byte;
              r_tx_last <= w_nxt_last & (r_pixel_idx == LAST_IDX);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_tx_data   = r_tx_data;
  assign o_tx_valid  = r_tx_valid;
  assign o_tx_last   = r_tx_last;
  assign o_busy      = r_busy;
  assign o_pixel_idx = r_pixel_idx;

endmodule

// File: tb/tb_readout_serializer.sv
// Directed bench for readout_serializer: a single-pixel instance for frame
// content and handshake, a 128-pixel instance for sweep, snapshot and reset.
module tb_readout_serializer;

  localparam int CB = 32;
  localparam int NP = 128;
  localparam int FL = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic          s1_start = 1'b0;
  logic          s1_ready = 1'b0;
  logic [CB-1:0] th1 = '0, tl1 = '0, per1 = '0;
  logic [7:0]    d1, p1;
  logic          v1, l1, b1;

  logic             s8_start = 1'b0;
  logic             s8_ready = 1'b0;
  logic [NP*CB-1:0] th8, tl8, per8;
  logic [7:0]       d8, p8;
  logic             v8, l8, b8;

  logic [7:0] exp1 [FL];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  readout_serializer #(.PIXELS(1), .COUNTER_BITS(CB), .HEADER(8'hA5)) u_one (
    .i_clk(clk), .i_rst(rst), .i_start(s1_start),
    .i_time_high_bus(th1), .i_time_low_bus(tl1), .i_period_bus(per1),
    .o_tx_data(d1), .o_tx_valid(v1), .i_tx_ready(s1_ready),
    .o_tx_last(l1), .o_busy(b1), .o_pixel_idx(p1)
  );

  readout_serializer #(.PIXELS(NP), .COUNTER_BITS(CB), .HEADER(8'hA5)) u_full (
    .i_clk(clk), .i_rst(rst), .i_start(s8_start),
    .i_time_high_bus(th8), .i_time_low_bus(tl8), .i_period_bus(per8),
    .o_tx_data(d8), .o_tx_valid(v8), .i_tx_ready(s8_ready),
    .o_tx_last(l8), .o_busy(b8), .o_pixel_idx(p8)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pattern();
    for (int i = 0; i < NP; i++) begin
      logic [7:0] b;
      b = 8'(i);
      th8[i*CB +: CB]  = {4{b}};
      tl8[i*CB +: CB]  = {4{b}};
      per8[i*CB +: CB] = {4{b}};
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    n_cmp++; if (d1 !== 8'h00) begin n_bad++; $display("FAIL rst_data1 got %h want 00", d1); end
    n_cmp++; if (v1 !== 1'b0) begin n_bad++; $display("FAIL rst_valid1 got %b want 0", v1); end
    n_cmp++; if (l1 !== 1'b0) begin n_bad++; $display("FAIL rst_last1 got %b want 0", l1); end
    n_cmp++; if (b1 !== 1'b0) begin n_bad++; $display("FAIL rst_busy1 got %b want 0", b1); end
    n_cmp++; if (p1 !== 8'h00) begin n_bad++; $display("FAIL rst_idx1 got %h want 00", p1); end
    n_cmp++; if (d8 !== 8'h00) begin n_bad++; $display("FAIL rst_data8 got %h want 00", d8); end
    n_cmp++; if (v8 !== 1'b0) begin n_bad++; $display("FAIL rst_valid8 got %b want 0", v8); end
    n_cmp++; if (b8 !== 1'b0) begin n_bad++; $display("FAIL rst_busy8 got %b want 0", b8); end
    rst = 1'b0;
    step();
    n_cmp++; if (b1 !== 1'b0 || v1 !== 1'b0) begin n_bad++; $display("FAIL post_rst_idle1 got busy=%b valid=%b want 0 0", b1, v1); end
  endtask

  task automatic test_single_frame();
    logic [7:0] chk;
    int n, cyc;
    th1 = 32'h11223344; tl1 = 32'h55667788; per1 = 32'h99AABBCC;
    exp1[0] = 8'hA5;
    exp1[1] = 8'h00;
    for (int j = 0; j < 4; j++) begin
      exp1[2+j]  = th1[31-8*j -: 8];
      exp1[6+j]  = tl1[31-8*j -: 8];
      exp1[10+j] = per1[31-8*j -: 8];
    end
    chk = 8'h00;
    for (int j = 1; j < 14; j++) chk ^= exp1[j];
    exp1[14] = chk;

    s1_ready = 1'b1;
    s1_start = 1'b1;
    step();
    s1_start = 1'b0;
    n_cmp++; if (v1 !== 1'b0 || b1 !== 1'b1) begin n_bad++; $display("FAIL latch_cycle got valid=%b busy=%b want 0 1", v1, b1); end
    step();
    n_cmp++; if (v1 !== 1'b1 || d1 !== 8'hA5) begin n_bad++; $display("FAIL first_byte got valid=%b data=%h want 1 a5", v1, d1); end

    n = 0; cyc = 0;
    while (n < FL && cyc < 40) begin
      if (v1 && s1_ready) begin
        n_cmp++; if (d1 !== exp1[n]) begin n_bad++; $display("FAIL frame1_byte%0d got %h want %h", n, d1, exp1[n]); end
        n_cmp++; if (l1 !== (n == FL-1)) begin n_bad++; $display("FAIL frame1_last%0d got %b want %b", n, l1, n == FL-1); end
        n++;
      end
      step();
      cyc++;
    end
    n_cmp++; if (n != FL) begin n_bad++; $display("FAIL frame1_timeout got %0d bytes want %0d", n, FL); end
    n_cmp++; if (cyc != FL) begin n_bad++; $display("FAIL frame1_back_to_back got %0d cycles want %0d", cyc, FL); end
    n_cmp++; if (v1 !== 1'b0 || b1 !== 1'b0 || l1 !== 1'b0) begin n_bad++; $display("FAIL frame1_end got valid=%b busy=%b last=%b want 0 0 0", v1, b1, l1); end
  endtask

  task automatic test_backpressure();
    int n, cyc;
    logic pv, pr, pl;
    logic [7:0] pd;
    s1_ready = 1'b0;
    s1_start = 1'b1;
    step();
    s1_start = 1'b0;
    n = 0; cyc = 0; pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = 8'h00;
    while (n < FL && cyc < 400) begin
      s1_ready = (cyc < 12) ? 1'b0 : 1'($urandom_range(0, 1));
      if (pv && !pr) begin
        n_cmp++;
        if (v1 !== 1'b1 || d1 !== pd || l1 !== pl) begin
          n_bad++;
          $display("FAIL bp_hold got valid=%b data=%h last=%b want 1 %h %b", v1, d1, l1, pd, pl);
        end
      end
      pv = v1; pr = s1_ready; pd = d1; pl = l1;
      if (v1 && s1_ready) begin
        n_cmp++; if (d1 !== exp1[n]) begin n_bad++; $display("FAIL bp_byte%0d got %h want %h", n, d1, exp1[n]); end
        n_cmp++; if (l1 !== (n == FL-1)) begin n_bad++; $display("FAIL bp_last%0d got %b want %b", n, l1, n == FL-1); end
        n++;
      end
      step();
      cyc++;
    end
    s1_ready = 1'b0;
    n_cmp++; if (n != FL) begin n_bad++; $display("FAIL bp_timeout got %0d bytes want %0d", n, FL); end
    n_cmp++; if (b1 !== 1'b0 || v1 !== 1'b0) begin n_bad++; $display("FAIL bp_end got busy=%b valid=%b want 0 0", b1, v1); end
  endtask

  task automatic test_sweep();
    int bcnt, cyc, idle, busycyc, pix, pos;
    logic [7:0] e;
    set_pattern();
    s8_ready = 1'b1;
    s8_start = 1'b1;
    step();
    s8_start = 1'b0;
    bcnt = 0; cyc = 0; idle = 0; busycyc = 0;
    while (bcnt < NP*FL && cyc < 4000) begin
      if (b8) busycyc++;
      if (b8 && !v8) idle++;
      s8_start = (cyc == 300 || cyc == 1500);
      if (v8 && s8_ready) begin
        pix = bcnt / FL;
        pos = bcnt % FL;
        e = (pos == 0) ? 8'hA5 : 8'(pix);
        n_cmp++; if (d8 !== e) begin n_bad++; $display("FAIL sweep_byte%0d got %h want %h", bcnt, d8, e); end
        n_cmp++; if (p8 !== 8'(pix)) begin n_bad++; $display("FAIL sweep_idx%0d got %h want %h", bcnt, p8, 8'(pix)); end
        n_cmp++; if (l8 !== (bcnt == NP*FL-1)) begin n_bad++; $display("FAIL sweep_last%0d got %b want %b", bcnt, l8, bcnt == NP*FL-1); end
        bcnt++;
      end
      // Scramble pixel 3 after its snapshot; only the latched value may appear.
      if (v8 && p8 == 8'd3) begin
        th8[3*CB +: CB]  = $urandom();
        tl8[3*CB +: CB]  = $urandom();
        per8[3*CB +: CB] = $urandom();
      end
      step();
      cyc++;
    end
    s8_start = 1'b0;
    n_cmp++; if (bcnt != NP*FL) begin n_bad++; $display("FAIL sweep_count got %0d want %0d", bcnt, NP*FL); end
    n_cmp++; if (idle != NP) begin n_bad++; $display("FAIL sweep_idle got %0d want %0d", idle, NP); end
    n_cmp++; if (busycyc != NP*(FL+1)) begin n_bad++; $display("FAIL sweep_busy_cycles got %0d want %0d", busycyc, NP*(FL+1)); end
    n_cmp++; if (b8 !== 1'b0 || v8 !== 1'b0 || l8 !== 1'b0) begin n_bad++; $display("FAIL sweep_end got busy=%b valid=%b last=%b want 0 0 0", b8, v8, l8); end
    repeat (3) step();
    n_cmp++; if (b8 !== 1'b0 || v8 !== 1'b0) begin n_bad++; $display("FAIL sweep_no_restart got busy=%b valid=%b want 0 0", b8, v8); end
    set_pattern();
  endtask

  task automatic test_reset_midframe();
    s8_ready = 1'b1;
    s8_start = 1'b1;
    step();
    s8_start = 1'b0;
    repeat (20) step();
    n_cmp++; if (v8 !== 1'b1 || p8 !== 8'd1) begin n_bad++; $display("FAIL mid_pre_reset got valid=%b idx=%h want 1 01", v8, p8); end
    rst = 1'b1;
    step();
    n_cmp++; if (v8 !== 1'b0 || b8 !== 1'b0) begin n_bad++; $display("FAIL mid_reset got valid=%b busy=%b want 0 0", v8, b8); end
    step();
    step();
    rst = 1'b0;
    step();
    n_cmp++; if (v8 !== 1'b0 || b8 !== 1'b0 || p8 !== 8'h00) begin n_bad++; $display("FAIL mid_after got valid=%b busy=%b idx=%h want 0 0 00", v8, b8, p8); end
    s8_start = 1'b1;
    step();
    s8_start = 1'b0;
    step();
    n_cmp++; if (v8 !== 1'b1 || d8 !== 8'hA5 || p8 !== 8'h00) begin n_bad++; $display("FAIL mid_restart got valid=%b data=%h idx=%h want 1 a5 00", v8, d8, p8); end
    step();
    n_cmp++; if (v8 !== 1'b1 || d8 !== 8'h00 || l8 !== 1'b0) begin n_bad++; $display("FAIL mid_idx_byte got valid=%b data=%h last=%b want 1 00 0", v8, d8, l8); end
  endtask

  initial begin
    set_pattern();
    test_reset();
    test_single_frame();
    test_backpressure();
    test_sweep();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
